bpf_alu_mc: RTL and testbench
=============================

Name: bpf_alu_mc

Overview:
- Next-generation BPF VM ALU, instantiated in bpfvm_datapath in place of the single-cycle ALU.
- Width is parametrised.
- Adds real multi-cycle multiply, divide and modulus, with a start/done handshake so bpfvm_ctrl can stall.
- Jump predicates (eq/gt/ge/set) stay available every cycle, optionally registered.

Parameters:
- WIDTH, 32, operand/result width; must be ≥ 2.
- PESSIMISTIC, 0, 1 = register the jump predicates (one-cycle delay); 0 = combinational.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- A  in  WIDTH  operand A (accumulator).
- B  in  WIDTH  operand B (X or immediate).
- ALU_sel  in  4  opcode; encoding below.
- start  in  1  launch operation; sampled only when busy=0.
- busy  out  1  iterative operation in progress.
- done  out  1  one-cycle pulse; ALU_out is valid from this cycle.
- ALU_out  out  WIDTH  result; held until the next accepted start.
- div_zero  out  1  sticky for the last op: divide or modulus by zero.
- eq, gt, ge, set  out  1  unsigned predicates on the live A, B.

Behaviour:
- Opcode encoding:
  - 0 add, 1 sub, 2 mul, 3 div, 4 or, 5 and, 6 shl, 7 shr, 8 not A, 9 mod, A xor.
  - B–F reserved: result 0, latency 1.
- All arithmetic is unsigned and modulo 2^WIDTH.
- Operands and ALU_sel are latched on accepted start. Later changes to A/B/ALU_sel do not affect an in-flight result.
- Shifts: amount taken from B; if B ≥ WIDTH the result is 0.
- States: IDLE, MUL, DIV, FIN.
  - IDLE, start, single-cycle op: compute and register the result, go to FIN. done pulses the next cycle (latency 1).
  - IDLE, start, op 2: go to MUL. Shift-add, one multiplier bit per cycle, WIDTH iterations, then FIN. Result is the low WIDTH bits of the product.
  - IDLE, start, op 3/9 with B≠0: go to DIV. Restoring division, one quotient bit per cycle, WIDTH iterations, then FIN. Op 3 yields the quotient, op 9 the remainder.
  - IDLE, start, op 3/9 with B=0: no iteration. Result 0, div_zero=1, go to FIN. Latency 1, matching BPF divide-by-zero semantics.
  - FIN: done=1 for exactly one cycle, then IDLE.
- Latency from accepted start to the done cycle: 1 for single-cycle ops; WIDTH+1 for mul and for div/mod with B≠0.
- busy is 1 in MUL, DIV and FIN; 0 in IDLE.
- start while busy=1 is ignored (no queueing, no corruption).
- start in the same cycle as FIN is ignored; the ALU is re-armable the cycle after done.
- div_zero is cleared on every accepted start and set only as described above.
- Predicates:
  - eq = A==B; gt = A>B; ge = gt|eq; set = (A&B)≠0.
  - Always computed from the live inputs, independent of the FSM.
  - PESSIMISTIC=1 adds exactly one register stage to the predicates only. It does not change ALU_out latency.
- Reset: state IDLE; busy=0, done=0, ALU_out=0, div_zero=0; predicate registers 0.
- Reset mid-operation aborts the operation: no done pulse; ALU_out returns to 0.
- Reset has priority over start in the same cycle.

Test Plan:
- WIDTH=32, A=0xFFFFFFFF, B=1, op add, start → done 1 cycle later; ALU_out=0. Op sub with A=0, B=1 → 0xFFFFFFFF.
- A=0x00012345, B=0x00010000, op mul → busy for 33 cycles; done at cycle 33; ALU_out=0x23450000 (truncated product).
- A=100, B=7, op div → ALU_out=14 at cycle 33. Same operands, op mod → ALU_out=2. div_zero=0 in both cases.
- A=5, B=0, op div → done at latency 1; ALU_out=0; div_zero=1. Next start with op add → div_zero clears.
- Op mul in progress: pulse start with op add, toggle A/B mid-operation, and assert rst at cycle 10.
  - Before rst: the second start has no effect; the mul result uses the latched operands.
  - After rst: busy=0, no done pulse, ALU_out=0.
- A=3, B=3 with PESSIMISTIC=1 → eq/ge rise one cycle after the inputs. Shl with B=32 → 0. Shr with B=31 on 0x80000000 → 1.

Source files
------------

// File: rtl/bpf_alu_mc_if.sv
// Operand/result bundle between the BPF VM controller/datapath and the multi-cycle ALU.
// The controller drives operands and start; the ALU returns status, result and predicates.
interface bpf_alu_mc_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_sel;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ALU_out;
    logic             div_zero;
    logic             eq;
    logic             gt;
    logic             ge;
    logic             set;

    modport master (
        output A, B, ALU_sel, start,
        input  busy, done, ALU_out, div_zero, eq, gt, ge, set
    );

    modport slave (
        input  A, B, ALU_sel, start,
        output busy, done, ALU_out, div_zero, eq, gt, ge, set
    );
endinterface

// File: rtl/bpf_alu_mc.sv
// BPF VM ALU with iterative shift-add multiply and restoring divide/modulus,
// start/done handshake, and live unsigned jump predicates (optionally registered).
//
// state | meaning
// IDLE  | waiting for start; predicates only
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// FIN   | result registered, done high for this one cycle
module bpf_alu_mc #(
    parameter int WIDTH       = 32,
    parameter bit PESSIMISTIC = 1'b0
) (
    input logic          clk,
    input logic          rst,
    bpf_alu_mc_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] W_LIMIT = WIDTH'(WIDTH);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_MOD = 4'h9;
    localparam logic [3:0] OP_XOR = 4'hA;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [3:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] single_res;
    logic [WIDTH:0]   rem_sh;
    logic [3:0]       pred_d;

    always_comb begin
        single_res = '0;
        case (bus.ALU_sel)
            OP_ADD:  single_res = bus.A + bus.B;
            OP_SUB:  single_res = bus.A - bus.B;
            OP_OR:   single_res = bus.A | bus.B;
            OP_AND:  single_res = bus.A & bus.B;
            OP_SHL:  single_res = (bus.B >= W_LIMIT) ? '0 : (bus.A << bus.B);
            OP_SHR:  single_res = (bus.B >= W_LIMIT) ? '0 : (bus.A >> bus.B);
            OP_NOT:  single_res = ~bus.A;
            OP_XOR:  single_res = bus.A ^ bus.B;
            default: single_res = '0;
        endcase
    end

    // Division reuses opa as the dividend/quotient shifter and acc as the partial remainder.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        out_d   = out_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        rem_sh  = {acc_q, opa_q[WIDTH-1]};

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    opa_d = bus.A;
                    opb_d = bus.B;
                    op_d  = bus.ALU_sel;
                    acc_d = '0;
                    cnt_d = CW'(WIDTH - 1);
                    dz_d  = 1'b0;
                    if (bus.ALU_sel == OP_MUL) begin
                        state_d = S_MUL;
                    end else if ((bus.ALU_sel == OP_DIV) || (bus.ALU_sel == OP_MOD)) begin
                        if (bus.B == '0) begin
                            out_d   = '0;
                            dz_d    = 1'b1;
                            state_d = S_FIN;
                        end else begin
                            state_d = S_DIV;
                        end
                    end else begin
                        out_d   = single_res;
                        state_d = S_FIN;
                    end
                end
            end
            S_MUL: begin
                if (opb_q[0]) begin
                    acc_d = acc_q + opa_q;
                end
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    out_d   = acc_d;
                    state_d = S_FIN;
                end
            end
            S_DIV: begin
                if (rem_sh >= {1'b0, opb_q}) begin
                    acc_d = rem_sh[WIDTH-1:0] - opb_q;
                    opa_d = {opa_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rem_sh[WIDTH-1:0];
                    opa_d = {opa_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    out_d   = (op_q == OP_MOD) ? acc_d : opa_d;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.ALU_out  = out_q;
    assign bus.div_zero = dz_q;

    // Predicates follow the live operands regardless of any operation in flight.
    always_comb begin
        pred_d[3] = (bus.A == bus.B);
        pred_d[2] = (bus.A > bus.B);
        pred_d[1] = (bus.A >= bus.B);
        pred_d[0] = ((bus.A & bus.B) != '0);
    end

    generate
        if (PESSIMISTIC) begin : g_pred_reg
            logic [3:0] pred_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    pred_q <= '0;
                end else begin
                    pred_q <= pred_d;
                end
            end
            assign {bus.eq, bus.gt, bus.ge, bus.set} = pred_q;
        end else begin : g_pred_comb
            assign {bus.eq, bus.gt, bus.ge, bus.set} = pred_d;
        end
    endgenerate
endmodule

// File: tb/tb_bpf_alu_mc.sv
// Directed-vector bench for bpf_alu_mc: one combinational-predicate instance drives all
// operations, a second registered-predicate instance shares its operands.
module tb_bpf_alu_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bpf_alu_mc_if #(.WIDTH(32)) bif ();
    bpf_alu_mc_if #(.WIDTH(32)) bif_p ();

    assign bif_p.A       = bif.A;
    assign bif_p.B       = bif.B;
    assign bif_p.ALU_sel = 4'h0;
    assign bif_p.start   = 1'b0;

    bpf_alu_mc #(.WIDTH(32), .PESSIMISTIC(1'b0)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    bpf_alu_mc #(.WIDTH(32), .PESSIMISTIC(1'b1)) u_dut_p (
        .clk (clk),
        .rst (rst),
        .bus (bif_p.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                          output int lat, output int nbusy);
        bif.A       = a;
        bif.B       = b;
        bif.ALU_sel = sel;
        bif.start   = 1'b1;
        step();
        bif.start = 1'b0;
        lat   = 1;
        nbusy = 0;
        while (!bif.done && lat < 100) begin
            if (bif.busy) nbusy++;
            step();
            lat++;
        end
        if (bif.busy) nbusy++;
    endtask

    task automatic op_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] sel, input logic [31:0] exp_res,
                            input int exp_lat, input logic exp_dz);
        int lat, nbusy;
        run_op(a, b, sel, lat, nbusy);
        chk({tag, "_res"}, bif.ALU_out, exp_res);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_dz"}, {31'b0, bif.div_zero}, {31'b0, exp_dz});
        step();
    endtask

    initial begin
        int lat, nbusy, ndone;
        bif.A       = '0;
        bif.B       = '0;
        bif.ALU_sel = '0;
        bif.start   = 1'b0;
        rst = 1'b1;
        step();
        step();
        chk("rst_busy", {31'b0, bif.busy}, 32'd0);
        chk("rst_done", {31'b0, bif.done}, 32'd0);
        chk("rst_out", bif.ALU_out, 32'd0);
        chk("rst_dz", {31'b0, bif.div_zero}, 32'd0);
        chk("rst_pred_p", {28'b0, bif_p.eq, bif_p.gt, bif_p.ge, bif_p.set}, 32'd0);
        rst = 1'b0;
        step();

        op_check("add_wrap", 32'hFFFF_FFFF, 32'd1, 4'h0, 32'h0, 1, 1'b0);
        op_check("sub_wrap", 32'h0, 32'd1, 4'h1, 32'hFFFF_FFFF, 1, 1'b0);

        run_op(32'h0001_2345, 32'h0001_0000, 4'h2, lat, nbusy);
        chk("mul_res", bif.ALU_out, 32'h2345_0000);
        chk("mul_lat", lat, 32'd33);
        chk("mul_busy_cycles", nbusy, 32'd33);
        step();
        chk("mul_idle_after", {31'b0, bif.busy}, 32'd0);

        op_check("div", 32'd100, 32'd7, 4'h3, 32'd14, 33, 1'b0);
        op_check("mod", 32'd100, 32'd7, 4'h9, 32'd2, 33, 1'b0);
        op_check("div_big", 32'hFFFF_FFFF, 32'h0001_0000, 4'h3, 32'h0000_FFFF, 33, 1'b0);
        op_check("div_zero", 32'd5, 32'd0, 4'h3, 32'd0, 1, 1'b1);
        op_check("add_clr_dz", 32'd2, 32'd3, 4'h0, 32'd5, 1, 1'b0);
        op_check("mod_zero", 32'd9, 32'd0, 4'h9, 32'd0, 1, 1'b1);
        op_check("or", 32'hF0F0_0000, 32'h0000_0F0F, 4'h4, 32'hF0F0_0F0F, 1, 1'b0);
        op_check("and", 32'hFF00_FF00, 32'h0FF0_0FF0, 4'h5, 32'h0F00_0F00, 1, 1'b0);
        op_check("shl4", 32'h0000_00AB, 32'd4, 4'h6, 32'h0000_0AB0, 1, 1'b0);
        op_check("shl32", 32'h0000_0001, 32'd32, 4'h6, 32'h0, 1, 1'b0);
        op_check("shr31", 32'h8000_0000, 32'd31, 4'h7, 32'h1, 1, 1'b0);
        op_check("not", 32'h1234_5678, 32'd0, 4'h8, 32'hEDCB_A987, 1, 1'b0);
        op_check("xor", 32'hAAAA_5555, 32'hFFFF_0000, 4'hA, 32'h5555_5555, 1, 1'b0);
        op_check("rsvd_b", 32'h1234_5678, 32'd1, 4'hB, 32'h0, 1, 1'b0);

        // start held into FIN must not relaunch
        bif.A = 32'd1; bif.B = 32'd2; bif.ALU_sel = 4'h0; bif.start = 1'b1;
        step();
        chk("fin_done", {31'b0, bif.done}, 32'd1);
        bif.A = 32'd10;
        step();
        bif.start = 1'b0;
        chk("fin_ign_busy", {31'b0, bif.busy}, 32'd0);
        chk("fin_ign_done", {31'b0, bif.done}, 32'd0);
        chk("fin_ign_out", bif.ALU_out, 32'd3);

        // predicates: combinational vs one-cycle registered
        bif.A = 32'd5; bif.B = 32'd3;
        step();
        bif.A = 32'd3; bif.B = 32'd3;
        #1;
        chk("pred_comb", {28'b0, bif.eq, bif.gt, bif.ge, bif.set}, 32'b1011);
        chk("pred_p_old", {28'b0, bif_p.eq, bif_p.gt, bif_p.ge, bif_p.set}, 32'b0111);
        step();
        chk("pred_p_new", {28'b0, bif_p.eq, bif_p.gt, bif_p.ge, bif_p.set}, 32'b1011);
        bif.A = 32'd4; bif.B = 32'd3;
        #1;
        chk("pred_noset", {28'b0, bif.eq, bif.gt, bif.ge, bif.set}, 32'b0110);
        bif.A = 32'd2; bif.B = 32'd6;
        #1;
        chk("pred_lt", {28'b0, bif.eq, bif.gt, bif.ge, bif.set}, 32'b0001);
        step();

        // mul with a stray start and operand churn mid-flight
        bif.A = 32'h0001_2345; bif.B = 32'h0001_0000; bif.ALU_sel = 4'h2; bif.start = 1'b1;
        step();
        bif.start = 1'b0;
        lat = 1;
        while (!bif.done && lat < 100) begin
            if (lat == 3) begin
                bif.start = 1'b1; bif.ALU_sel = 4'h0; bif.A = 32'd1; bif.B = 32'd1;
            end else begin
                bif.start = 1'b0; bif.A = 32'hDEAD_BEEF; bif.B = lat;
            end
            step();
            lat++;
        end
        bif.start = 1'b0;
        chk("mul_intf_res", bif.ALU_out, 32'h2345_0000);
        chk("mul_intf_lat", lat, 32'd33);
        step();

        // mul aborted by reset at cycle 10
        bif.A = 32'd7; bif.B = 32'd6; bif.ALU_sel = 4'h2; bif.start = 1'b1;
        step();
        bif.start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (c == 4) begin
                bif.start = 1'b1; bif.ALU_sel = 4'h0;
            end else begin
                bif.start = 1'b0;
            end
            step();
        end
        bif.start = 1'b0;
        chk("abort_pre_busy", {31'b0, bif.busy}, 32'd1);
        chk("abort_pre_done", {31'b0, bif.done}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", {31'b0, bif.busy}, 32'd0);
        chk("abort_out", bif.ALU_out, 32'd0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (bif.done) ndone++;
            step();
        end
        chk("abort_no_done", ndone, 32'd0);

        // reset wins over a simultaneous start
        bif.A = 32'd9; bif.B = 32'd4; bif.ALU_sel = 4'h0; bif.start = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; bif.start = 1'b0;
        step();
        chk("rst_prio_done", {31'b0, bif.done}, 32'd0);
        chk("rst_prio_out", bif.ALU_out, 32'd0);

        op_check("rearm_add", 32'd9, 32'd4, 4'h0, 32'd13, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
